serial_subtractor_8bit: RTL and testbench



---
 rtl/serial_subtractor_8bit.sv | 185 ++++++++++++++++++
 tb/tb_serial_subtractor_8bit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_8bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit
// Bit-serial ripple subtractor: D = a - b - bin (modulo 2^WIDTH), computed
// one bit per clock through a single full-subtractor slice and a registered
// borrow. Control is a start/busy/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request pulse, honoured only in IDLE
//   a, b   minuend / subtrahend, captured on an accepted start
//   bin    borrow-in, captured on an accepted start
//   busy   high while bits are being shifted (SHIFT)
//   done   single-cycle pulse, D/bout valid from this cycle
//   D      difference, held until the next accepted start
//   bout   final borrow-out (a < b + bin, unsigned), held like D
//   ovf    two's-complement overflow (only with SERIAL_SUB_SIGNED_OVF_EN)
//
// Optional feature macro: SERIAL_SUB_SIGNED_OVF_EN
// ---------------------------------------------------------------------------
module serial_subtractor_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               bout_q, bout_d;

    // Full-subtractor slice on the current LSBs
    logic               x_c, y_c, diff_c, borrow_c;

    assign x_c      = a_q[0];
    assign y_c      = b_q[0];
    assign diff_c   = x_c ^ y_c ^ br_q;
    assign borrow_c = (~x_c & y_c) | (~(x_c ^ y_c) & br_q);

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    dout_d  = '0;
                    bout_d  = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    ovf_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                // LSB-first: after WIDTH shifts the first diff lands in bit 0
                res_d = {diff_c, res_q[WIDTH-1:1]};
                br_d  = borrow_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done_d  = 1'b1;
                dout_d  = res_q;
                bout_d  = br_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                // Overflow only when operand signs differ and result sign flips away from a
                ovf_d   = (a_msb_q != b_msb_q) & (res_q[WIDTH-1] != a_msb_q);
`endif
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // busy mirrors the state we are entering so it lines up with SHIFT
        busy_d = (state_d == SHIFT);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = dout_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_8bit
// Directed self-checking bench for serial_subtractor_8bit (WIDTH = 8).
// ---------------------------------------------------------------------------
module tb_serial_subtractor_8bit;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;
`endif

    int n_cmp;
    int n_err;

    serial_subtractor_8bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse and follow the operation to its done pulse.
    // lat = posedges after the start edge until done is seen (-1 on timeout).
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av; b = ~bv; bin = ~bi;   // later input changes must not matter
        lat = -1;
        busy_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = n;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (D !== 8'h00) begin n_err++; $display("FAIL reset_D got %h want 00", D); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL reset_bout got %b want 0", bout); end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(8'h5A, 8'h3C, 1'b0, lat, bc);
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL basic_latency got %0d want 9", lat); end
        n_cmp++; if (bc !== 8) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
        n_cmp++; if (D !== 8'h1E) begin n_err++; $display("FAIL basic_D got %h want 1e", D); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL basic_bout got %b want 0", bout); end
        repeat (3) @(negedge clk);
        n_cmp++; if (D !== 8'h1E) begin n_err++; $display("FAIL basic_D_hold got %h want 1e", D); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_low got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        int lat, bc;
        run_op(8'h00, 8'h01, 1'b0, lat, bc);
        n_cmp++; if (D !== 8'hFF) begin n_err++; $display("FAIL wrap0_D got %h want ff", D); end
        n_cmp++; if (bout !== 1'b1) begin n_err++; $display("FAIL wrap0_bout got %b want 1", bout); end
        run_op(8'hFF, 8'hFF, 1'b1, lat, bc);
        n_cmp++; if (D !== 8'hFF) begin n_err++; $display("FAIL wrap1_D got %h want ff", D); end
        n_cmp++; if (bout !== 1'b1) begin n_err++; $display("FAIL wrap1_bout got %b want 1", bout); end
    endtask

    task automatic test_borrow_chain();
        int lat, bc;
        run_op(8'h10, 8'h0F, 1'b1, lat, bc);
        n_cmp++; if (D !== 8'h00) begin n_err++; $display("FAIL chain0_D got %h want 00", D); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL chain0_bout got %b want 0", bout); end
        run_op(8'h10, 8'h10, 1'b1, lat, bc);
        n_cmp++; if (D !== 8'hFF) begin n_err++; $display("FAIL chain1_D got %h want ff", D); end
        n_cmp++; if (bout !== 1'b1) begin n_err++; $display("FAIL chain1_bout got %b want 1", bout); end
    endtask

    task automatic test_ignored_start();
        int dones;
        logic [7:0] d_at_done;
        dones = 0;
        d_at_done = 8'hXX;
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;   // mid-SHIFT request
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                d_at_done = D;
            end
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL ignored_done_count got %0d want 1", dones); end
        n_cmp++; if (d_at_done !== 8'h1E) begin n_err++; $display("FAIL ignored_D got %h want 1e", d_at_done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int dones, lat, bc;
        dones = 0;
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", done); end
        n_cmp++; if (D !== 8'h00) begin n_err++; $display("FAIL rstmid_D got %h want 00", D); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL rstmid_bout got %b want 0", bout); end
        rst = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL rstmid_no_done got %0d want 0", dones); end
        run_op(8'h5A, 8'h3C, 1'b0, lat, bc);
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL rstmid_relat got %0d want 9", lat); end
        n_cmp++; if (D !== 8'h1E) begin n_err++; $display("FAIL rstmid_reD got %h want 1e", D); end
    endtask

    task automatic test_back_to_back();
        int t, first, second, dones;
        first = -1; second = -1; dones = 0;
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        for (t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done) begin
                if (dones == 0) first = t;
                else if (dones == 1) second = t;
                dones++;
                n_cmp++; if (D !== 8'h1E) begin n_err++; $display("FAIL b2b_D got %h want 1e", D); end
            end
        end
        start = 1'b0;
        n_cmp++; if (dones !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", dones); end
        n_cmp++; if (second - first !== 10) begin n_err++; $display("FAIL b2b_spacing got %0d want 10", second - first); end
        repeat (15) @(negedge clk);
    endtask

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    task automatic test_ovf();
        int lat, bc;
        run_op(8'h80, 8'h01, 1'b0, lat, bc);
        n_cmp++; if (D !== 8'h7F) begin n_err++; $display("FAIL ovf0_D got %h want 7f", D); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf0_ovf got %b want 1", ovf); end
        n_cmp++; if (bout !== 1'b0) begin n_err++; $display("FAIL ovf0_bout got %b want 0", bout); end
        run_op(8'h7F, 8'hFF, 1'b0, lat, bc);
        n_cmp++; if (D !== 8'h80) begin n_err++; $display("FAIL ovf1_D got %h want 80", D); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf1_ovf got %b want 1", ovf); end
        n_cmp++; if (bout !== 1'b1) begin n_err++; $display("FAIL ovf1_bout got %b want 1", bout); end
        run_op(8'h05, 8'h03, 1'b0, lat, bc);
        n_cmp++; if (D !== 8'h02) begin n_err++; $display("FAIL ovf2_D got %h want 02", D); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf2_ovf got %b want 0", ovf); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_borrow_chain();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
